// File: rtl/gmii_rx_frame.sv
// GMII receive front end: strips preamble/SFD, checks the FCS, length and rx_er,
// removes the FCS and streams the payload with sop/eop framing and a frame verdict.
module gmii_rx_frame #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk_125,
  input  logic             reset_n,
  input  logic [7:0]       mac_rxd,
  input  logic             mac_rx_dv,
  input  logic             mac_rx_er,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  output logic             rx_sop,
  output logic             rx_eop,
  output logic             rx_good,
  output logic             rx_bad,
  output logic [15:0]      rx_len,
  output logic [CNT_W-1:0] stat_good,
  output logic [CNT_W-1:0] stat_bad
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_start;
  logic        w_beat;
  logic        w_end;
  logic        w_good;
  logic [31:0] w_crc_next;
  logic [31:0] r_crc;
  logic [15:0] r_cnt;
  logic        r_err;
  logic        r_sent;
  logic [2:0]  r_fill;
  logic [7:0]  r_buf [0:4];

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < 8; i++) begin
      x = (x[0] ^ d[i]) ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    end
    return x;
  endfunction

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_beat       = 1'b0;
    w_end        = 1'b0;
    case (r_state)
      IDLE, PREAMBLE: begin
        if (!mac_rx_dv) begin
          w_state_next = IDLE;
        end else if (mac_rxd == 8'h55) begin
          w_state_next = PREAMBLE;
        end else if (mac_rxd == 8'hD5) begin
          w_state_next = DATA;
          w_start      = 1'b1;
        end else begin
          w_state_next = DROP;
        end
      end
      DATA: begin
        if (mac_rx_dv) begin
          w_beat = 1'b1;
        end else begin
          w_end        = 1'b1;
          w_state_next = IDLE;
        end
      end
      DROP: if (!mac_rx_dv) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_crc_next = crc_byte(r_crc, mac_rxd);
  // 0xDEBB20E3 is the register residue after running a correct FCS through the CRC
  assign w_good = (r_crc == 32'hDEBB20E3) && (r_cnt >= 16'(MIN_LEN)) &&
                  (r_cnt <= 16'(MAX_LEN)) && !r_err;

  always_ff @(posedge clk_125 or negedge reset_n) begin
    if (!reset_n) begin
      r_crc     <= 32'hFFFFFFFF;
      r_cnt     <= 16'd0;
      r_err     <= 1'b0;
      r_sent    <= 1'b0;
      r_fill    <= 3'd0;
      for (int i = 0; i < 5; i++) r_buf[i] <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_sop    <= 1'b0;
      rx_eop    <= 1'b0;
      rx_good   <= 1'b0;
      rx_bad    <= 1'b0;
      rx_len    <= 16'd0;
      stat_good <= '0;
      stat_bad  <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_sop   <= 1'b0;
      rx_eop   <= 1'b0;
      rx_good  <= 1'b0;
      rx_bad   <= 1'b0;
      if (w_start) begin
        r_crc  <= 32'hFFFFFFFF;
        r_cnt  <= 16'd0;
        r_err  <= 1'b0;
        r_sent <= 1'b0;
        r_fill <= 3'd0;
      end
      if (w_beat) begin
        r_crc <= w_crc_next;
        if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
        if (mac_rx_er) r_err <= 1'b1;
        r_buf[0] <= mac_rxd;
        for (int i = 1; i < 5; i++) r_buf[i] <= r_buf[i-1];
        if (r_fill == 3'd5) begin
          rx_data  <= r_buf[4];
          rx_valid <= 1'b1;
          rx_sop   <= !r_sent;
          r_sent   <= 1'b1;
        end else begin
          r_fill <= r_fill + 3'd1;
        end
      end
      // A full buffer at frame end holds the last payload byte plus the 4 FCS bytes
      if (w_end) begin
        r_fill <= 3'd0;
        if (r_fill == 3'd5) begin
          rx_data  <= r_buf[4];
          rx_valid <= 1'b1;
          rx_eop   <= 1'b1;
          rx_sop   <= !r_sent;
          rx_good  <= w_good;
          rx_bad   <= !w_good;
          rx_len   <= r_cnt;
          if (w_good) begin
            if (stat_good != '1) stat_good <= stat_good + CNT_W'(1);
          end else begin
            if (stat_bad != '1) stat_bad <= stat_bad + CNT_W'(1);
          end
        end else begin
          if (stat_bad != '1) stat_bad <= stat_bad + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Bench for gmii_rx_frame: table of frames plus hand-written corner sequences,
// with expected payload beats queued as bytes are driven and checked as they emerge.
module tb_gmii_rx_frame;

  localparam int CNT_W = 16;

  logic             clk_125 = 1'b0;
  logic             reset_n;
  logic [7:0]       mac_rxd;
  logic             mac_rx_dv;
  logic             mac_rx_er;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_sop;
  logic             rx_eop;
  logic             rx_good;
  logic             rx_bad;
  logic [15:0]      rx_len;
  logic [CNT_W-1:0] stat_good;
  logic [CNT_W-1:0] stat_bad;

  always #4 clk_125 = ~clk_125;

  gmii_rx_frame #(.MIN_LEN(64), .MAX_LEN(1518), .CNT_W(CNT_W)) dut (
    .clk_125   (clk_125),
    .reset_n   (reset_n),
    .mac_rxd   (mac_rxd),
    .mac_rx_dv (mac_rx_dv),
    .mac_rx_er (mac_rx_er),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sop    (rx_sop),
    .rx_eop    (rx_eop),
    .rx_good   (rx_good),
    .rx_bad    (rx_bad),
    .rx_len    (rx_len),
    .stat_good (stat_good),
    .stat_bad  (stat_bad)
  );

  typedef struct {
    logic [7:0]  data;
    bit          sop;
    bit          eop;
    bit          good;
    logic [15:0] len;
  } beat_t;

  typedef struct {
    int plen;
    bit corrupt;
    int er_idx;
    int pre_n;
    int gap;
    bit exp_good;
  } vec_t;

  beat_t       sb[$];
  beat_t       mon_e;
  logic [7:0]  frm[$];
  vec_t        vecs[9];
  int          checks = 0;
  int          passes = 0;
  logic [15:0] exp_g = 16'd0;
  logic [15:0] exp_b = 16'd0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%h expected=%h", name, got, exp);
  endtask

  // Byte-wise reflected CRC-32: xor the byte in, then eight shift/conditional-xor steps
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  task automatic build(input int plen, input bit corrupt);
    logic [31:0] c;
    logic [31:0] fcs;
    frm.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      frm.push_back(i[7:0]);
      c = crc_model(c, i[7:0]);
    end
    fcs = ~c;
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
    if (corrupt) frm[plen] = frm[plen] ^ 8'h01;
  endtask

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(negedge clk_125);
    mac_rxd   = b;
    mac_rx_dv = dv;
    mac_rx_er = er;
  endtask

  task automatic push_beat(input int j, input int npay, input bit good);
    beat_t b;
    b.data = frm[j];
    b.sop  = (j == 0);
    b.eop  = (j == npay - 1);
    b.good = good;
    b.len  = 16'(frm.size());
    sb.push_back(b);
  endtask

  task automatic send(input int pre_n, input int er_idx, input bit good);
    int npay;
    npay = frm.size() - 4;
    for (int i = 0; i < pre_n; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int j = 0; j < frm.size(); j++) begin
      drive(frm[j], 1'b1, (j == er_idx));
      if (j < npay) push_beat(j, npay, good);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  task automatic check_stats(input string name);
    chk({name, "_drain"}, 64'(sb.size()), 64'd0);
    sb.delete();
    chk({name, "_stats"}, {stat_good, stat_bad}, {exp_g, exp_b});
  endtask

  always @(negedge clk_125) begin
    if (rx_valid) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_beat got data=%h sop=%b eop=%b expected=no beat",
                 rx_data, rx_sop, rx_eop);
      end else begin
        mon_e = sb.pop_front();
        chk("beat",
            {rx_data, rx_sop, rx_eop, rx_good, rx_bad, (rx_eop ? rx_len : 16'h0)},
            {mon_e.data, mon_e.sop, mon_e.eop, mon_e.eop & mon_e.good,
             mon_e.eop & !mon_e.good, (mon_e.eop ? mon_e.len : 16'h0)});
        if (mon_e.eop)
          $display("frame eop len=%0d good=%b bad=%b", rx_len, rx_good, rx_bad);
      end
    end else if (rx_sop || rx_eop || rx_good || rx_bad) begin
      checks++;
      $display("FAIL stray_pulse got sop=%b eop=%b good=%b bad=%b expected=none without rx_valid",
               rx_sop, rx_eop, rx_good, rx_bad);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=still running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // plen, corrupt, er_idx, pre_n, gap, exp_good
    vecs[0] = '{60,   1'b0, -1, 7, 4, 1'b1};
    vecs[1] = '{60,   1'b1, -1, 7, 4, 1'b0};
    vecs[2] = '{60,   1'b0, 10, 7, 4, 1'b0};
    vecs[3] = '{59,   1'b0, -1, 7, 4, 1'b0};
    vecs[4] = '{1515, 1'b0, -1, 7, 4, 1'b0};
    vecs[5] = '{1514, 1'b0, -1, 7, 4, 1'b1};
    vecs[6] = '{60,   1'b0, -1, 0, 4, 1'b1};
    vecs[7] = '{60,   1'b0, -1, 7, 1, 1'b1};
    vecs[8] = '{100,  1'b0, -1, 1, 4, 1'b1};

    reset_n   = 1'b0;
    mac_rxd   = 8'h00;
    mac_rx_dv = 1'b0;
    mac_rx_er = 1'b0;
    repeat (3) @(negedge clk_125);
    chk("reset_state",
        {rx_data, rx_valid, rx_sop, rx_eop, rx_good, rx_bad, rx_len, stat_good, stat_bad},
        64'd0);
    reset_n = 1'b1;
    idle(2);

    foreach (vecs[v]) begin
      build(vecs[v].plen, vecs[v].corrupt);
      send(vecs[v].pre_n, vecs[v].er_idx, vecs[v].exp_good);
      idle(vecs[v].gap);
      if (vecs[v].exp_good) exp_g++;
      else                  exp_b++;
      if (vecs[v].gap >= 3) check_stats($sformatf("vec%0d", v));
      if (vecs[v].er_idx >= 0) begin
        for (int i = 0; i < 4; i++) drive(8'h0F, 1'b0, 1'b1);
        idle(3);
        check_stats("carrier_ext");
      end
    end

    // Short frame: only 3 bytes after the SFD
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    drive(8'h01, 1'b1, 1'b0);
    drive(8'h02, 1'b1, 1'b0);
    drive(8'h03, 1'b1, 1'b0);
    idle(4);
    exp_b++;
    check_stats("short");

    // Bad preamble: stays in DROP even if an SFD shows up later
    drive(8'h55, 1'b1, 1'b0);
    drive(8'h12, 1'b1, 1'b0);
    drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) drive(8'hA0 + 8'(i), 1'b1, 1'b0);
    idle(4);
    check_stats("bad_preamble");

    // Reset during payload byte 20, released while dv is still high
    build(60, 1'b0);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int j = 0; j <= 20; j++) begin
      drive(frm[j], 1'b1, 1'b0);
      if (j < 20) push_beat(j, 60, 1'b1);
    end
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_reset",
        {rx_data, rx_valid, rx_sop, rx_eop, rx_good, rx_bad, rx_len, stat_good, stat_bad},
        64'd0);
    exp_g = 16'd0;
    exp_b = 16'd0;
    for (int j = 21; j <= 40; j++) begin
      drive(frm[j], 1'b1, 1'b0);
      if (j == 26) #2 reset_n = 1'b1;
    end
    idle(4);
    check_stats("after_reset");

    build(64, 1'b0);
    send(7, -1, 1'b1);
    idle(4);
    exp_g++;
    check_stats("post_reset_frame");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
